// File: rtl/bcd_conv_sched_pkg.sv
// Shared types and constants for the BCD converter scheduler.
package bcd_sched_pkg;

    // Scheduler states: settle the converter, wait for work, wait for the result.
    typedef enum logic [1:0] {
        ST_DRAIN = 2'd0,
        ST_IDLE  = 2'd1,
        ST_WAIT  = 2'd2
    } sched_state_t;

    localparam int BIN_W    = 12;   // binary operand width
    localparam int BCD_W    = 16;   // four packed BCD digits
    localparam int CONV_LAT = 26;   // converter edges from en to rdy

    // Returned in place of a result when the converter never answered.
    localparam logic [BCD_W-1:0] BCD_ERR = 16'hFFFF;

endpackage

// File: rtl/bcd_conv_sched_rr_arbiter.sv
// Combinational round-robin pick: first asserted request at or above ptr,
// wrapping around. The pointer register is owned by the parent.
module rr_arbiter #(
    parameter  int N_REQ = 4,
    localparam int IDX_W = $clog2(N_REQ)
) (
    input  logic [N_REQ-1:0] req,
    input  logic [IDX_W-1:0] ptr,
    output logic [N_REQ-1:0] grant_oh,
    output logic [IDX_W-1:0] grant_idx,
    output logic             any_req
);

    logic [IDX_W:0]   sum_s;
    logic [IDX_W-1:0] cand_s;
    logic             found_s;

    // Scan from the pointer upwards, taking the first requester found.
    always_comb begin
        grant_oh  = '0;
        grant_idx = '0;
        found_s   = 1'b0;
        sum_s     = '0;
        cand_s    = '0;
        for (int k = 0; k < N_REQ; k++) begin
            sum_s = {1'b0, ptr} + (IDX_W+1)'(k);
            if (sum_s >= (IDX_W+1)'(N_REQ)) begin
                sum_s = sum_s - (IDX_W+1)'(N_REQ);
            end else begin
                sum_s = sum_s;
            end
            cand_s = sum_s[IDX_W-1:0];
            if (!found_s && req[cand_s]) begin
                found_s          = 1'b1;
                grant_idx        = cand_s;
                grant_oh[cand_s] = 1'b1;
            end else begin
                found_s = found_s;
            end
        end
        any_req = |req;
    end

endmodule

// File: rtl/bcd_conv_sched.sv
// Round-robin scheduler sharing one double-dabble converter among N_REQ
// requesters. The converter has no reset, so a drain period follows reset
// and every timeout to swallow any rdy still in flight.
module bcd_conv_sched
    import bcd_sched_pkg::*;
#(
    parameter int N_REQ   = 4,
    parameter int TIMEOUT = 31,
    parameter int DRAIN   = 32
) (
    input  logic                     clk,
    input  logic                     rst,
    input  logic [N_REQ-1:0]         req,
    input  logic [BIN_W*N_REQ-1:0]   req_data,
    output logic [N_REQ-1:0]         gnt,
    output logic                     res_valid,
    output logic [$clog2(N_REQ)-1:0] res_id,
    output logic [BCD_W-1:0]         res_bcd,
    output logic                     res_err,
    output logic                     busy,
    output logic                     conv_en,
    output logic [BIN_W-1:0]         conv_bin,
    input  logic [BCD_W-1:0]         conv_bcd,
    input  logic                     conv_rdy
);

    localparam int ID_W    = $clog2(N_REQ);
    // Never give up before the converter could possibly have answered.
    localparam int TMO_LIM = (TIMEOUT > CONV_LAT) ? TIMEOUT : CONV_LAT + 1;
    localparam int DRN_LIM = (DRAIN > CONV_LAT + 1) ? DRAIN : CONV_LAT + 2;
    localparam int CNT_MAX = (TMO_LIM > DRN_LIM) ? TMO_LIM : DRN_LIM;
    localparam int CNT_W   = $clog2(CNT_MAX + 1);

    sched_state_t      state_r, state_nxt_s;
    logic [CNT_W-1:0]  cnt_r, cnt_nxt_s;       // drain countdown / wait timer
    logic [ID_W-1:0]   ptr_r, ptr_nxt_s;

    logic [N_REQ-1:0]  win_oh_s;
    logic [ID_W-1:0]   win_idx_s;
    logic              any_req_s;
    logic [BIN_W-1:0]  win_data_s;
    logic              timeout_s;

    logic [N_REQ-1:0]  gnt_nxt_s;
    logic              res_valid_nxt_s;
    logic [ID_W-1:0]   res_id_nxt_s;
    logic [BCD_W-1:0]  res_bcd_nxt_s;
    logic              res_err_nxt_s;
    logic              busy_nxt_s;
    logic              conv_en_nxt_s;
    logic [BIN_W-1:0]  conv_bin_nxt_s;

    rr_arbiter #(.N_REQ(N_REQ)) u_arb (
        .req       (req),
        .ptr       (ptr_r),
        .grant_oh  (win_oh_s),
        .grant_idx (win_idx_s),
        .any_req   (any_req_s)
    );

    assign timeout_s = (cnt_r == CNT_W'(TMO_LIM - 1));

    // Select the winning requester's operand.
    always_comb begin
        win_data_s = '0;
        for (int k = 0; k < N_REQ; k++) begin
            if (win_idx_s == ID_W'(k)) begin
                win_data_s = req_data[k*BIN_W +: BIN_W];
            end else begin
                win_data_s = win_data_s;
            end
        end
    end

    // State, counter and round-robin pointer registers.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_r <= ST_DRAIN;
            cnt_r   <= CNT_W'(DRN_LIM);
            ptr_r   <= '0;
        end else begin
            state_r <= state_nxt_s;
            cnt_r   <= cnt_nxt_s;
            ptr_r   <= ptr_nxt_s;
        end
    end

    // Next-state, counter and pointer decisions.
    always_comb begin
        state_nxt_s = state_r;
        cnt_nxt_s   = cnt_r;
        ptr_nxt_s   = ptr_r;
        case (state_r)
            ST_DRAIN: begin
                if (cnt_r <= CNT_W'(1)) begin
                    state_nxt_s = ST_IDLE;
                    cnt_nxt_s   = '0;
                end else begin
                    cnt_nxt_s = cnt_r - CNT_W'(1);
                end
            end
            ST_IDLE: begin
                if (any_req_s) begin
                    state_nxt_s = ST_WAIT;
                    cnt_nxt_s   = '0;
                    if (win_idx_s == ID_W'(N_REQ - 1)) begin
                        ptr_nxt_s = '0;
                    end else begin
                        ptr_nxt_s = win_idx_s + ID_W'(1);
                    end
                end else begin
                    state_nxt_s = ST_IDLE;
                end
            end
            ST_WAIT: begin
                // rdy takes priority over a simultaneous timeout.
                if (conv_rdy) begin
                    state_nxt_s = ST_IDLE;
                    cnt_nxt_s   = '0;
                end else if (timeout_s) begin
                    state_nxt_s = ST_DRAIN;
                    cnt_nxt_s   = CNT_W'(DRN_LIM);
                end else begin
                    cnt_nxt_s = cnt_r + CNT_W'(1);
                end
            end
            default: begin
                state_nxt_s = ST_DRAIN;
                cnt_nxt_s   = CNT_W'(DRN_LIM);
            end
        endcase
    end

    // Next values of the registered outputs.
    always_comb begin
        gnt_nxt_s       = '0;
        conv_en_nxt_s   = 1'b0;
        conv_bin_nxt_s  = conv_bin;
        res_valid_nxt_s = 1'b0;
        res_id_nxt_s    = res_id;
        res_bcd_nxt_s   = res_bcd;
        res_err_nxt_s   = res_err;
        busy_nxt_s      = (state_nxt_s != ST_IDLE);
        case (state_r)
            ST_IDLE: begin
                if (any_req_s) begin
                    gnt_nxt_s      = win_oh_s;
                    conv_en_nxt_s  = 1'b1;
                    conv_bin_nxt_s = win_data_s;
                    res_id_nxt_s   = win_idx_s;
                end else begin
                    gnt_nxt_s = '0;
                end
            end
            ST_WAIT: begin
                if (conv_rdy) begin
                    res_valid_nxt_s = 1'b1;
                    res_bcd_nxt_s   = conv_bcd;
                    res_err_nxt_s   = 1'b0;
                end else if (timeout_s) begin
                    res_valid_nxt_s = 1'b1;
                    res_bcd_nxt_s   = BCD_ERR;
                    res_err_nxt_s   = 1'b1;
                end else begin
                    res_valid_nxt_s = 1'b0;
                end
            end
            ST_DRAIN: begin
                res_valid_nxt_s = 1'b0;
            end
            default: begin
                res_valid_nxt_s = 1'b0;
            end
        endcase
    end

    // Output registers; busy comes out of reset high because we start draining.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            gnt       <= '0;
            res_valid <= 1'b0;
            res_id    <= '0;
            res_bcd   <= '0;
            res_err   <= 1'b0;
            busy      <= 1'b1;
            conv_en   <= 1'b0;
            conv_bin  <= '0;
        end else begin
            gnt       <= gnt_nxt_s;
            res_valid <= res_valid_nxt_s;
            res_id    <= res_id_nxt_s;
            res_bcd   <= res_bcd_nxt_s;
            res_err   <= res_err_nxt_s;
            busy      <= busy_nxt_s;
            conv_en   <= conv_en_nxt_s;
            conv_bin  <= conv_bin_nxt_s;
        end
    end

endmodule
